// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble sequence monitor.
package nibble_pkg;

   typedef logic [3:0] nibble_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GOT0,
      S_GOT1
   } seq_state_t;

   localparam nibble_t NIBBLE_ZERO  = 4'h0;
   localparam nibble_t DEFAULT_SEQ0 = 4'hD;
   localparam nibble_t DEFAULT_SEQ1 = 4'h5;
   localparam nibble_t DEFAULT_SEQ2 = 4'hA;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Count register: clear wins over increment, increment stops at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/nibble_seq_monitor.sv
// Detects the three-word sequence SEQ0,SEQ1,SEQ2 on a valid/ready nibble stream,
// raises a held match event, counts matches and flags accepted zero words.
module nibble_seq_monitor
   import nibble_pkg::*;
#(
   parameter nibble_t     SEQ0  = DEFAULT_SEQ0,
   parameter nibble_t     SEQ1  = DEFAULT_SEQ1,
   parameter nibble_t     SEQ2  = DEFAULT_SEQ2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   input  nibble_t          in_data,
   output logic             in_ready,
   output logic             match_valid,
   input  logic             match_ready,
   output logic [CNT_W-1:0] match_count,
   output logic             zero_err,
   output logic             busy
);

   // A zero word can never be part of the sequence, so a zero sequence word is unusable.
   if (SEQ0 == NIBBLE_ZERO || SEQ1 == NIBBLE_ZERO || SEQ2 == NIBBLE_ZERO) begin : g_bad_seq
      $error("nibble_seq_monitor: sequence words must be non-zero");
   end
   if (CNT_W < 2) begin : g_bad_cnt_w
      $error("nibble_seq_monitor: CNT_W must be at least 2");
   end

   seq_state_t state, state_next;
   logic       beat;
   logic       zero_beat;
   logic       do_match;
   logic       match_valid_next;
   logic       zero_err_next;

   // Only a pending, untaken event stalls the producer.
   assign in_ready  = !(match_valid && !match_ready);
   assign beat      = in_valid && in_ready;
   assign zero_beat = beat && (in_data == NIBBLE_ZERO);
   assign busy      = (state != S_IDLE);

   // Next state, match detection, event and error flags; clear overrides everything.
   always_comb begin
      state_next       = state;
      do_match         = 1'b0;
      match_valid_next = match_valid;
      zero_err_next    = zero_err;

      if (beat) begin
         if (zero_beat) begin
            state_next    = S_IDLE;
            zero_err_next = 1'b1;
         end else begin
            // Sequence compare is checked before the SEQ0 restart so equal words still advance.
            unique case (state)
               S_IDLE: begin
                  if (in_data == SEQ0) state_next = S_GOT0;
               end
               S_GOT0: begin
                  if (in_data == SEQ1)      state_next = S_GOT1;
                  else if (in_data == SEQ0) state_next = S_GOT0;
                  else                      state_next = S_IDLE;
               end
               S_GOT1: begin
                  if (in_data == SEQ2) begin
                     state_next = S_IDLE;
                     do_match   = 1'b1;
                  end else if (in_data == SEQ0) begin
                     state_next = S_GOT0;
                  end else begin
                     state_next = S_IDLE;
                  end
               end
               default: state_next = S_IDLE;
            endcase
         end
      end

      // A new match keeps the event raised even when the old one is taken this edge.
      if (do_match) begin
         match_valid_next = 1'b1;
      end else if (match_valid && match_ready) begin
         match_valid_next = 1'b0;
      end

      if (clear) begin
         state_next       = S_IDLE;
         match_valid_next = 1'b0;
         zero_err_next    = 1'b0;
      end
   end

   // State, event and sticky error registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         match_valid <= 1'b0;
         zero_err    <= 1'b0;
      end else begin
         state       <= state_next;
         match_valid <= match_valid_next;
         zero_err    <= zero_err_next;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_match_cnt (
      .clk    (clk),
      .reset_n(reset_n),
      .inc    (do_match && !clear),
      .clr    (clear),
      .count  (match_count)
   );

   // Clear is exempted from the hold properties since it legitimately drops the event and state.
   a_event_held: assert property (@(posedge clk) disable iff (!reset_n)
      match_valid && !match_ready && !clear |=> match_valid);
   a_count_monotonic: assert property (@(posedge clk) disable iff (!reset_n)
      !clear |=> match_count >= $past(match_count));
   a_stall_freezes_state: assert property (@(posedge clk) disable iff (!reset_n)
      !in_ready && !clear |=> state == $past(state));

endmodule

// File: tb/tb_nibble_seq_monitor.sv
// Bench for nibble_seq_monitor: directed scenarios plus random traffic against a
// history-queue reference model; a CNT_W=2 instance shares the stimulus.
module tb_nibble_seq_monitor;

   logic       clk;
   logic       reset_n;
   logic       clear;
   logic       in_valid;
   logic [3:0] in_data;
   logic       match_ready;

   logic       in_ready, match_valid, zero_err, busy;
   logic [7:0] match_count;
   logic       in_ready2, match_valid2, zero_err2, busy2;
   logic [1:0] match_count2;

   nibble_seq_monitor dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .match_valid(match_valid),
      .match_ready(match_ready),
      .match_count(match_count),
      .zero_err   (zero_err),
      .busy       (busy)
   );

   nibble_seq_monitor #(
      .CNT_W(2)
   ) dut2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready2),
      .match_valid(match_valid2),
      .match_ready(match_ready),
      .match_count(match_count2),
      .zero_err   (zero_err2),
      .busy       (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: words accepted since the last restart point, trimmed to the longest
   // suffix that is still a prefix of the target sequence.
   logic [3:0] seq [3];
   logic [3:0] hist [$];
   bit         m_mv;
   bit         m_err;
   int         m_cnt;
   int         m_cnt2;

   task automatic model_reset();
      hist.delete();
      m_mv   = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
   endtask

   function automatic bit model_ready(input logic mr);
      return !(m_mv && !mr);
   endfunction

   task automatic model_update(input logic v, input logic [3:0] d, input logic mr,
                               input logic clr);
      bit beat;
      bit hit;
      bit ok;
      int k;
      beat = v && model_ready(mr);
      hit  = 1'b0;
      if (clr) begin
         model_reset();
         return;
      end
      if (beat) begin
         if (d == 4'h0) begin
            m_err = 1'b1;
            hist.delete();
         end else begin
            hist.push_back(d);
            if (hist.size() == 3 && hist[0] == seq[0] && hist[1] == seq[1] &&
                hist[2] == seq[2]) begin
               hit = 1'b1;
               hist.delete();
            end else begin
               k = 0;
               for (int n = 2; n >= 1; n--) begin
                  if (k == 0 && hist.size() >= n) begin
                     ok = 1'b1;
                     for (int i = 0; i < n; i++)
                        if (hist[hist.size() - n + i] != seq[i]) ok = 1'b0;
                     if (ok) k = n;
                  end
               end
               while (hist.size() > k) void'(hist.pop_front());
            end
         end
      end
      if (hit) begin
         m_mv = 1'b1;
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end else if (m_mv && mr) begin
         m_mv = 1'b0;
      end
   endtask

   task automatic check_outputs();
      check("match_valid", match_valid, m_mv);
      check("match_count", match_count, m_cnt);
      check("zero_err", zero_err, m_err);
      check("busy", busy, hist.size() != 0);
      check("match_valid_w2", match_valid2, m_mv);
      check("match_count_w2", match_count2, m_cnt2);
      check("zero_err_w2", zero_err2, m_err);
      check("busy_w2", busy2, hist.size() != 0);
   endtask

   // One clock of stimulus; called shortly after a rising edge.
   task automatic step(input logic v, input logic [3:0] d, input logic mr, input logic clr);
      in_valid    = v;
      in_data     = d;
      match_ready = mr;
      clear       = clr;
      #1;
      check("in_ready", in_ready, model_ready(mr));
      check("in_ready_w2", in_ready2, model_ready(mr));
      @(posedge clk);
      model_update(v, d, mr, clr);
      #1;
      check_outputs();
   endtask

   task automatic send_seq(input logic mr);
      step(1'b1, 4'hD, mr, 1'b0);
      step(1'b1, 4'h5, mr, 1'b0);
      step(1'b1, 4'hA, mr, 1'b0);
   endtask

   task automatic do_clear();
      step(1'b0, 4'h0, 1'b1, 1'b1);
   endtask

   logic [3:0] rd;
   int         r;

   initial begin
      seq[0] = 4'hD;
      seq[1] = 4'h5;
      seq[2] = 4'hA;
      reset_n     = 1'b0;
      clear       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 4'h0;
      match_ready = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_match_valid", match_valid, 0);
      check("rst_match_count", match_count, 0);
      check("rst_zero_err", zero_err, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;

      // Basic match: event one cycle after the SEQ2 beat, for exactly one cycle
      send_seq(1'b1);
      check("t2_mv", match_valid, 1);
      check("t2_cnt", match_count, 1);
      step(1'b0, 4'h0, 1'b1, 1'b0);
      check("t2_mv_drop", match_valid, 0);

      // Repeated SEQ0 restarts, then an aborted sequence
      do_clear();
      step(1'b1, 4'hD, 1'b1, 1'b0);
      send_seq(1'b1);
      step(1'b1, 4'hD, 1'b1, 1'b0);
      step(1'b1, 4'h5, 1'b1, 1'b0);
      check("t3_busy_mid", busy, 1);
      step(1'b1, 4'h3, 1'b1, 1'b0);
      check("t3_cnt", match_count, 1);
      check("t3_idle", busy, 0);

      // Stalled event blocks input, then taken while the next sequence runs
      do_clear();
      send_seq(1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'hD, 1'b0, 1'b0);
         check("t4_stall_ready", in_ready, 0);
      end
      check("t4_cnt_held", match_count, 1);
      check("t4_mv_held", match_valid, 1);
      send_seq(1'b1);
      check("t4_mv", match_valid, 1);
      check("t4_cnt", match_count, 2);

      // Zero word aborts the sequence and sticks until clear
      do_clear();
      step(1'b1, 4'hD, 1'b1, 1'b0);
      step(1'b1, 4'h0, 1'b1, 1'b0);
      step(1'b1, 4'h5, 1'b1, 1'b0);
      step(1'b1, 4'hA, 1'b1, 1'b0);
      check("t5_err", zero_err, 1);
      check("t5_nomatch", match_count, 0);
      step(1'b0, 4'h0, 1'b1, 1'b0);
      check("t5_err_sticky", zero_err, 1);
      do_clear();
      check("t5_err_clr", zero_err, 0);
      check("t5_cnt_clr", match_count, 0);

      // Clear beats a same-cycle completing beat
      send_seq(1'b1);
      step(1'b1, 4'hD, 1'b1, 1'b0);
      step(1'b1, 4'h5, 1'b1, 1'b0);
      step(1'b1, 4'hA, 1'b1, 1'b1);
      check("clr_vs_match_cnt", match_count, 0);
      check("clr_vs_match_mv", match_valid, 0);

      // Saturation on the narrow counter, then reset mid-sequence
      for (int i = 0; i < 5; i++) send_seq(1'b1);
      check("t6_sat_w2", match_count2, 3);
      check("t6_cnt_w8", match_count, 5);
      step(1'b1, 4'hD, 1'b1, 1'b0);
      step(1'b1, 4'h5, 1'b1, 1'b0);
      check("t6_busy_pre", busy, 1);
      reset_n = 1'b0;
      #1;
      model_reset();
      check("t6_busy_rst", busy, 0);
      check("t6_busy_rst_w2", busy2, 0);
      check("t6_cnt_rst", match_count, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 4'hA, 1'b1, 1'b0);
      check("t6_no_resume", match_count, 0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: rd = 4'hD;
            3, 4:    rd = 4'h5;
            5, 6:    rd = 4'hA;
            7:       rd = 4'h0;
            default: rd = 4'($urandom_range(0, 15));
         endcase
         step(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 4) < 3),
              ($urandom_range(0, 39) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
